gray_bin_updown_counter: RTL
============================

Name: gray_bin_updown_counter

Overview:
Parametrised successor to the 4-bit gray/binary counter. It is an up/down counter of WIDTH bits with enable, synchronous clear and parallel load. The load value can be given as binary or as gray code. The block registers both binary and gray outputs and flags overflow/underflow. It serves as the generic counter primitive for pointer and sequence generation, for example FIFO pointers crossing clock domains and encoder position tracking.

Parameters:
WIDTH, 4, counter width in bits (>=2).
WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at 0 / 2^WIDTH-1.
LOAD_GRAY, 0, 1 = load_val is gray-coded and converted to binary internally; 0 = load_val is binary.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
clr  input  1  synchronous clear to zero.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  load value; encoding selected by LOAD_GRAY.
en  input  1  count enable.
up_dn  input  1  1 = count up, 0 = count down.
bin_count  output  WIDTH  registered binary count.
gray_count  output  WIDTH  registered gray count, always equal to bin_count ^ (bin_count >> 1).
ovf  output  1  registered one-cycle pulse: an enabled count step was attempted past a bound.
at_bound  output  1  registered level: count = 2^WIDTH-1 when up_dn=1, or 0 when up_dn=0 (based on the current up_dn).

Behaviour:
- Reset: rst=0 asynchronously forces bin_count=0, gray_count=0, ovf=0, at_bound=0, regardless of clk.
- Release: rst deasserts asynchronously. The first counting edge is the first rising clk with rst=1.
- Per-edge priority: clr > load > en. Inputs outside the winning action are ignored.
- clr=1: next bin=0; ovf=0.
- load=1 (clr=0):
  - LOAD_GRAY=0: next bin = load_val.
  - LOAD_GRAY=1: next bin = gray-to-binary(load_val), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
  - ovf=0 on a load edge.
- en=1 (clr=load=0):
  - up_dn=1, bin<max: next bin = bin+1.
  - up_dn=1, bin=max: WRAP=1 gives next bin=0; WRAP=0 holds max. ovf=1 next cycle in both cases.
  - up_dn=0, bin>0: next bin = bin-1.
  - up_dn=0, bin=0: WRAP=1 gives next bin=max; WRAP=0 holds 0. ovf=1 next cycle in both cases.
- en=0, no clr/load: hold; ovf=0.
- Arithmetic is WIDTH bits unsigned; carry/borrow is discarded except for ovf detection.
- gray_count is computed from next bin and registered on the same edge as bin_count:
  - Zero-latency relationship between the two outputs.
  - Exactly one gray bit toggles per ±1 step, including wrap (max↔0).
  - Load/clear may change several bits.
- Direction change: up_dn may change on any cycle and takes effect on that edge. No dead cycle.
- at_bound is a combinational function of the registered count and the current up_dn, registered one cycle behind. Simultaneous up_dn change: at_bound reflects the new direction one edge later.
- ovf is high for exactly one cycle per overflow step. Back-to-back overflow steps (WRAP=0, held at bound with en=1) keep ovf high each cycle.

Test Plan:
- Reset: WIDTH=4, hold rst=0 for 2 clocks with en=1 -> bin=0000, gray=0000, ovf=0. Assert rst=0 mid-count at bin=0101 between edges -> outputs 0 immediately, without waiting for clk.
- Up-count wrap: WIDTH=4, WRAP=1, en=1, up_dn=1 for 17 edges from 0.
  - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - ovf=1 only in the cycle after the 15→0 edge.
  - Every step checked for single-bit gray change.
- Down/saturate: WRAP=0, load_val=0010, load=1, then up_dn=0, en=1 for 4 edges -> bin 2,1,0,0,0; ovf=1 on the two held cycles; at_bound=1 once bin=0.
- Gray load: LOAD_GRAY=1, load_val=1101 -> bin=1001 (9), gray=1101. Next up step -> bin=1010, gray=1111.
- Priority: clr=1, load=1, en=1 on the same edge -> bin=0. Then load=1, en=1, load_val=0111 (LOAD_GRAY=0) -> bin=0111, no increment.
- Direction flip: count up to 0110, flip up_dn=0 with en=1 -> 0101 on the next edge. Then en=0 for 3 edges -> holds 0101, ovf=0.

Source files
------------

// File: rtl/gray_bin_updown_counter.sv
// Parametrised up/down counter with registered binary and gray outputs,
// synchronous clear, binary or gray parallel load, and overflow/bound flags.
module gray_bin_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          WRAP      = 1'b1,
    parameter bit          LOAD_GRAY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_count,
    output logic             ovf,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_at_bound;

    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_d;
    logic [WIDTH-1:0] w_gray_d;
    logic             w_ovf_d;
    logic             w_at_bound_d;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_g2b = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_g2b[i] = ^(load_val >> i);
        end
    end

    assign w_load_bin = LOAD_GRAY ? w_g2b : load_val;

    always_comb begin
        w_bin_d = r_bin;
        w_ovf_d = 1'b0;
        if (clr) begin
            w_bin_d = '0;
        end else if (load) begin
            w_bin_d = w_load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (r_bin == MAX) begin
                    w_ovf_d = 1'b1;
                    w_bin_d = WRAP ? '0 : MAX;
                end else begin
                    w_bin_d = r_bin + WIDTH'(1);
                end
            end else begin
                if (r_bin == '0) begin
                    w_ovf_d = 1'b1;
                    w_bin_d = WRAP ? MAX : '0;
                end else begin
                    w_bin_d = r_bin - WIDTH'(1);
                end
            end
        end
    end

    assign w_gray_d     = w_bin_d ^ (w_bin_d >> 1);
    // Bound is judged on the pre-edge count, so it trails the count by one edge.
    assign w_at_bound_d = up_dn ? (r_bin == MAX) : (r_bin == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin      <= '0;
            r_gray     <= '0;
            r_ovf      <= 1'b0;
            r_at_bound <= 1'b0;
        end else begin
            r_bin      <= w_bin_d;
            r_gray     <= w_gray_d;
            r_ovf      <= w_ovf_d;
            r_at_bound <= w_at_bound_d;
        end
    end

    assign bin_count  = r_bin;
    assign gray_count = r_gray;
    assign ovf        = r_ovf;
    assign at_bound   = r_at_bound;

endmodule
